// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Registered, mode-selectable immediate extender for the decode/execute
// boundary. An IN_W-bit immediate is extended to OUT_W bits combinationally
// at the input, then held in a 2-entry skid buffer. This lets the stage
// absorb an execute stall without dropping or duplicating data, and keeps
// in_ready free of any combinational path from out_ready.
//
// Modes (in_mode):
//   00 sign   : sign-extend
//   01 zero   : zero-extend
//   10 upper  : immediate in the top IN_W bits, zeros below (LUI)
//   11 branch : sign-extend, then shift left by 2
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake
//   in_imm, in_mode     raw immediate and its extension mode
//   out_valid/out_ready consumer handshake
//   out_data            extended immediate
//   xfer_count          fire counter, 16 bits, wraps (only when
//                       IMM_EXTEND_PIPE_COUNT_EN is defined)
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXTEND_PIPE_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    localparam int S = OUT_W - IN_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [OUT_W-1:0] sext, zext, ext;
    logic             acc, fire;

    assign sext = {{S{in_imm[IN_W-1]}}, in_imm};
    assign zext = {{S{1'b0}}, in_imm};

    // Left shifts on OUT_W-wide values drop whatever is pushed past the MSB,
    // which is exactly the truncation the upper and branch modes need.
    always_comb begin
        ext = sext;
        case (in_mode)
            2'b00:   ext = sext;
            2'b01:   ext = zext;
            2'b10:   ext = zext << S;
            default: ext = sext << 2;
        endcase
    end

    // Handshake outputs come from registered state only (plus reset gating).
    assign in_ready  = !reset && (state_q != ST_TWO);
    assign out_valid = !reset && (state_q != ST_EMPTY);
    assign out_data  = out_q;

    assign acc  = in_valid && in_ready;
    assign fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    out_d   = ext;
                end
            end
            ST_ONE: begin
                if (acc && fire) begin
                    out_d = ext;
                end else if (acc) begin
                    // Consumer stalled: park the new entry behind out_q.
                    state_d = ST_TWO;
                    skid_d  = ext;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (fire) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifdef IMM_EXTEND_PIPE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        v8 = 1'b0;
    logic        r8;
    logic [7:0]  imm8 = '0;
    logic [1:0]  md8 = '0;
    logic        ov8;
    logic [15:0] od8;

`ifdef IMM_EXTEND_PIPE_COUNT_EN
    logic [15:0] xfer_count;
    logic [15:0] xfer_count8;
`endif

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef IMM_EXTEND_PIPE_COUNT_EN
        , .xfer_count(xfer_count)
`endif
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(r8),
        .in_imm(imm8), .in_mode(md8),
        .out_valid(ov8), .out_ready(1'b1), .out_data(od8)
`ifdef IMM_EXTEND_PIPE_COUNT_EN
        , .xfer_count(xfer_count8)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: FIFO of expected outputs, capacity 2.
    longint unsigned q[$];
    int unsigned     fires_total;
    logic [15:0]     fcnt;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Extension rules evaluated arithmetically on the integer value.
    function automatic longint unsigned ext_model(longint unsigned imm, int md, int inw, int outw);
        longint          sv;
        longint unsigned mask;
        mask = (64'd1 << outw) - 64'd1;
        if (imm >= (64'd1 << (inw - 1))) sv = longint'(imm) - (longint'(1) << inw);
        else                             sv = longint'(imm);
        case (md)
            0:       return longint'(sv) & mask;
            1:       return imm;
            2:       return (imm * (64'd1 << (outw - inw))) & mask;
            default: return longint'(sv * 4) & mask;
        endcase
    endfunction

    // Drive one cycle (called at a negedge), advance the model across the
    // coming posedge, then check DUT outputs at the following negedge.
    task automatic cyc(input logic rst, input logic iv, input logic [15:0] imm,
                       input logic [1:0] md, input logic ordy);
        bit mv, mr, acc, fire;
        reset = rst; in_valid = iv; in_imm = imm; in_mode = md; out_ready = ordy;
        if (rst) begin
            q.delete();
            fcnt = '0;
        end else begin
            mv   = q.size() > 0;
            mr   = q.size() < 2;
            fire = mv && ordy;
            acc  = iv && mr;
            if (fire) begin
                void'(q.pop_front());
                fcnt = fcnt + 16'd1;
                fires_total++;
            end
            if (acc) q.push_back(ext_model(imm, md, 16, 32));
        end
        @(negedge clk);
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
        end else begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) chk("out_data", out_data, q[0]);
        end
`ifdef IMM_EXTEND_PIPE_COUNT_EN
        chk("xfer_count", xfer_count, fcnt);
`endif
    endtask

    initial begin
        fires_total = 0;
        fcnt = '0;
        @(negedge clk);

        // Reset held two cycles with in_valid high.
        cyc(1, 1, 16'h1234, 0, 1);
        cyc(1, 1, 16'h1234, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // All four modes on 0x8001.
        for (int m = 0; m < 4; m++) cyc(0, 1, 16'h8001, m[1:0], 1);
        cyc(0, 0, 0, 0, 1);

        // Stall: A then B fill the buffer, consumer later drains both.
        cyc(0, 1, 16'h0001, 0, 0);
        cyc(0, 1, 16'h0002, 0, 0);
        cyc(0, 1, 16'h0003, 0, 0);   // refused, in_ready low
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Back-to-back stream.
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'(16'h0100 + i), 2'($urandom_range(3)), 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Reset while full: buffered entries must vanish.
        cyc(0, 1, 16'hAAAA, 1, 0);
        cyc(0, 1, 16'h5555, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                16'($urandom), 2'($urandom_range(3)), ($urandom_range(2) != 0));
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Narrow instance: 8 -> 16.
        v8 = 1'b1; imm8 = 8'h80; md8 = 2'b00;
        @(negedge clk);
        chk("w8_valid_sign", ov8, 1);
        chk("w8_sign", od8, ext_model(64'h80, 0, 8, 16));
        md8 = 2'b10;
        @(negedge clk);
        chk("w8_valid_upper", ov8, 1);
        chk("w8_upper", od8, ext_model(64'h80, 2, 8, 16));
        v8 = 1'b0;
        @(negedge clk);
        chk("w8_drain", ov8, 0);

`ifdef IMM_EXTEND_PIPE_COUNT_EN
        // Counter wrap: 65537 fires after reset leaves the count at 1.
        cyc(1, 0, 0, 0, 1);
        fires_total = 0;
        for (int i = 0; i < 70000 && fires_total < 65537; i++)
            cyc(0, 1, 16'(i), 2'(i), 1);
        chk("fires_reached", fires_total, 65537);
        chk("xfer_wrap", xfer_count, 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
